// File: rtl/alu_div_if.sv
// Operand/result bundle between the EX-stage issue logic and the multi-cycle divider.
`ifndef WORD_BUS
`define WORD_BUS 31:0
`endif
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif

interface alu_div_if;
  logic            start;
  logic            signed_op;
  logic [`WORD_BUS] dividend;
  logic [`WORD_BUS] divisor;
  logic            cancel;
  logic            stall;
  logic            o_we;
  logic [`WORD_BUS] o_hi;
  logic [`WORD_BUS] o_lo;

  modport master (output start, signed_op, dividend, divisor, cancel,
                  input  stall, o_we, o_hi, o_lo);
  modport slave  (input  start, signed_op, dividend, divisor, cancel,
                  output stall, o_we, o_hi, o_lo);
endinterface

// File: rtl/alu_div.sv
// Radix-2 restoring DIV/DIVU, one quotient bit per clock; remainder -> HI, quotient -> LO.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes the next cycle.
`ifndef WORD_BUS
`define WORD_BUS 31:0
`endif
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif

module alu_div (
  input logic       clk,
  input logic       rst,
  alu_div_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nextState;
  logic [4:0]       cnt;
  logic [`WORD_BUS] rem, quo, divMag, hiReg, loReg;
  logic             quoNeg, remNeg;
  logic             accept, zeroFast, dvdNeg, dvsNeg, stallC, weC;
  logic [32:0]      shifted, trial;
  logic [`WORD_BUS] quoNext, remNext, quoFinal, remFinal;

  assign accept = (state == IDLE) && bus.start && !bus.cancel;
  assign dvdNeg = bus.signed_op && bus.dividend[31];
  assign dvsNeg = bus.signed_op && bus.divisor[31];
`ifdef DIV_ZERO_FAST_EN
  assign zeroFast = (bus.divisor == `ZERO_WORD);
`else
  assign zeroFast = `DISABLE;
`endif

  // One restoring step: the quotient register doubles as the dividend shifter.
  assign shifted  = {rem, quo[31]};
  assign trial    = shifted - {1'b0, divMag};
  assign quoNext  = {quo[30:0], ~trial[32]};
  assign remNext  = trial[32] ? shifted[31:0] : trial[31:0];
  assign quoFinal = quoNeg ? -quoNext : quoNext;
  assign remFinal = remNeg ? -remNext : remNext;

  always_comb begin
    nextState = state;
    stallC    = `DISABLE;
    weC       = `DISABLE;
    case (state)
      IDLE: if (accept) begin
        stallC    = `ENABLE;
        nextState = zeroFast ? DONE : RUN;
      end
      RUN: begin
        stallC = `ENABLE;
        if (cnt == 5'd31) nextState = DONE;
      end
      DONE: begin
        weC       = `ENABLE;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // A flush squashes both the hold request's future and any pending write.
    if (bus.cancel) begin
      nextState = IDLE;
      weC       = `DISABLE;
    end
  end

  assign bus.stall = stallC;
  assign bus.o_we  = weC;
  assign bus.o_hi  = weC ? hiReg : `ZERO_WORD;
  assign bus.o_lo  = weC ? loReg : `ZERO_WORD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      rem    <= `ZERO_WORD;
      quo    <= `ZERO_WORD;
      divMag <= `ZERO_WORD;
      quoNeg <= `DISABLE;
      remNeg <= `DISABLE;
      hiReg  <= `ZERO_WORD;
      loReg  <= `ZERO_WORD;
    end else begin
      state <= nextState;
      case (state)
        IDLE: if (accept) begin
          quo    <= dvdNeg ? -bus.dividend : bus.dividend;
          divMag <= dvsNeg ? -bus.divisor : bus.divisor;
          quoNeg <= dvdNeg ^ dvsNeg;
          remNeg <= dvdNeg;
          rem    <= `ZERO_WORD;
          cnt    <= 5'd0;
          if (zeroFast) begin
            hiReg <= bus.dividend;
            loReg <= dvdNeg ? 32'h0000_0001 : 32'hFFFF_FFFF;
          end
        end
        RUN: begin
          rem <= remNext;
          quo <= quoNext;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hiReg <= remFinal;
            loReg <= quoFinal;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_div.sv
// Directed vector table plus cancel/reset sequences for the multi-cycle divider.
module tb_alu_div;
  logic clk = 1'b0;
  logic rst;
  alu_div_if bus ();

  alu_div dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sOp;
    logic [31:0] dvd, dvs, expLo, expHi;
  } vec_t;
  vec_t vecs[9];

`ifdef DIV_ZERO_FAST_EN
  localparam int ZeroLat = 1;
`else
  localparam int ZeroLat = 33;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; that half-cycle is cycle 0 of the request.
  task automatic runCheck(input string nm, input logic sOp, input logic [31:0] dvd,
                          input logic [31:0] dvs, input logic [31:0] expLo,
                          input logic [31:0] expHi, input int expLat);
    int lat = -1;
    int stallErrs = 0;
    logic [31:0] lo = 0, hi = 0;
    bus.start = 1'b1; bus.signed_op = sOp; bus.dividend = dvd; bus.divisor = dvs;
    #1;
    if (bus.stall !== 1'b1 || bus.o_we !== 1'b0) stallErrs++;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = 32'hDEAD_BEEF; bus.divisor = 32'h1234_5678;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.stall !== (c < expLat)) stallErrs++;
      if (bus.o_we === 1'b1) begin lat = c; lo = bus.o_lo; hi = bus.o_hi; end
    end
    chk({nm, " latency"}, lat, expLat);
    chk({nm, " lo"}, lo, expLo);
    chk({nm, " hi"}, hi, expHi);
    chk({nm, " stall errs"}, stallErrs, 0);
    @(negedge clk);
    chk({nm, " post we/hi/lo"}, {31'd0, bus.o_we} | bus.o_hi | bus.o_lo, 32'd0);
  endtask

  initial begin
    int weSeen;
    vecs[0] = '{1'b0, 32'd100,       32'd7,        32'd14,        32'd2};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF};
    vecs[2] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  32'd0};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  32'd0};
    vecs[5] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,         32'h80000000};
    vecs[6] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE};
    vecs[7] = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF,  32'd5};
    vecs[8] = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'd1,         32'hFFFFFFFB};

    rst = 1'b1; bus.start = 1'b0; bus.signed_op = 1'b0; bus.cancel = 1'b0;
    bus.dividend = 32'd0; bus.divisor = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {29'd0, bus.stall, bus.o_we, 1'b0} | bus.o_hi | bus.o_lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: each new start lands in the cycle right after DONE.
    for (int i = 0; i < 9; i++)
      runCheck($sformatf("vec%0d", i), vecs[i].sOp, vecs[i].dvd, vecs[i].dvs,
               vecs[i].expLo, vecs[i].expHi, (vecs[i].dvs == 0) ? ZeroLat : 33);

    // Cancel in cycle 10, then a fresh DIVU 9/3 started in cycle 11.
    weSeen = 0;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.o_we !== 1'b0) weSeen++;
    end
    bus.cancel = 1'b1;
    @(posedge clk); #1 bus.cancel = 1'b0;
    @(negedge clk);
    chk("cancel stall c11", {31'd0, bus.stall}, 32'd0);
    chk("cancel no we", weSeen + bus.o_we, 0);
    runCheck("after cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Reset in cycle 20 of a division.
    weSeen = 0;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst outputs c21", {29'd0, bus.stall, bus.o_we, 1'b0} | bus.o_hi | bus.o_lo, 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.o_we !== 1'b0 || bus.stall !== 1'b0) weSeen++;
    end
    chk("rst no we", weSeen, 0);
    runCheck("after rst", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
